// File: rtl/sw_job_feeder_if.sv
// Host, engine and result signals of the Smith-Waterman job feeder.
// The feeder takes the slave side; the host/engine environment the master side.
interface sw_job_feeder_if #(
    parameter int ADDR_W = 7
);
    logic              wr_en;
    logic              wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [1:0]        wr_data;
    logic              start;
    logic              busy;
    logic              eng_rst;
    logic              valid;
    logic [1:0]        data_s;
    logic [1:0]        data_t;
    logic              finish;
    logic [11:0]       max;
    logic              result_valid;
    logic              result_ready;
    logic [11:0]       result;
    logic              timeout;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start,
        output finish, max, result_ready,
        input  busy, eng_rst, valid, data_s, data_t,
        input  result_valid, result, timeout
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start,
        input  finish, max, result_ready,
        output busy, eng_rst, valid, data_s, data_t,
        output result_valid, result, timeout
    );
endinterface

// File: rtl/sw_job_feeder.sv
// Job controller for the Smith-Waterman engine: resets it, streams S/T,
// waits for finish (or times out) and returns the score on a valid/ready port.
module sw_job_feeder #(
    parameter int S_LEN      = 64,
    parameter int T_LEN      = 64,
    parameter int ADDR_W     = 7,
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic           clk,
    input  logic           reset,
    sw_job_feeder_if.slave bus
);
    localparam int L  = (S_LEN > T_LEN) ? S_LEN : T_LEN;
    localparam int AW = (L > 1) ? $clog2(L) : 1;
    localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [AW-1:0]   IDX_LAST  = AW'(L - 1);
    localparam logic [CW-1:0]   CLR_INIT  = CW'(CLR_CYCLES - 1);
    localparam logic [WW-1:0]   WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [ADDR_W:0] S_WLIM    = (ADDR_W + 1)'(S_LEN);
    localparam logic [ADDR_W:0] T_WLIM    = (ADDR_W + 1)'(T_LEN);
    localparam logic [AW:0]     S_RLIM    = (AW + 1)'(S_LEN);
    localparam logic [AW:0]     T_RLIM    = (AW + 1)'(T_LEN);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        STREAM,
        WAIT,
        HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] clr_cnt_q, clr_cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic        busy_q, busy_d;
    logic        eng_rst_q, eng_rst_d;
    logic        valid_q, valid_d;
    logic [1:0]  data_s_q, data_s_d;
    logic [1:0]  data_t_q, data_t_d;
    logic        rvalid_q, rvalid_d;
    logic [11:0] result_q, result_d;
    logic        timeout_q, timeout_d;

    // Symbol stores are deliberately unreset so they survive reset and jobs.
    logic [1:0] s_mem [2**AW];
    logic [1:0] t_mem [2**AW];
    logic       s_wr, t_wr;

    assign s_wr = bus.wr_en && (state_q == IDLE) && !bus.wr_sel
                  && ({1'b0, bus.wr_addr} < S_WLIM);
    assign t_wr = bus.wr_en && (state_q == IDLE) && bus.wr_sel
                  && ({1'b0, bus.wr_addr} < T_WLIM);

    always_ff @(posedge clk) begin
        if (s_wr) s_mem[bus.wr_addr[AW-1:0]] <= bus.wr_data;
        if (t_wr) t_mem[bus.wr_addr[AW-1:0]] <= bus.wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            clr_cnt_q  <= '0;
            idx_q      <= '0;
            wait_cnt_q <= '0;
            busy_q     <= 1'b0;
            eng_rst_q  <= 1'b0;
            valid_q    <= 1'b0;
            data_s_q   <= 2'b00;
            data_t_q   <= 2'b00;
            rvalid_q   <= 1'b0;
            result_q   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            idx_q      <= idx_d;
            wait_cnt_q <= wait_cnt_d;
            busy_q     <= busy_d;
            eng_rst_q  <= eng_rst_d;
            valid_q    <= valid_d;
            data_s_q   <= data_s_d;
            data_t_q   <= data_t_d;
            rvalid_q   <= rvalid_d;
            result_q   <= result_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = CLR;
            CLR:     if (clr_cnt_q == '0) state_d = STREAM;
            STREAM:  if (idx_q == IDX_LAST) state_d = WAIT;
            WAIT:    if (bus.finish || (wait_cnt_q == WAIT_LAST)) state_d = HOLD;
            HOLD:    if (bus.result_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so every port is a flop.
    always_comb begin
        clr_cnt_d  = clr_cnt_q;
        idx_d      = idx_q;
        wait_cnt_d = wait_cnt_q;
        result_d   = result_q;
        timeout_d  = timeout_q;
        case (state_q)
            IDLE: clr_cnt_d = CLR_INIT;
            CLR: begin
                idx_d = '0;
                if (clr_cnt_q != '0) clr_cnt_d = clr_cnt_q - CW'(1);
            end
            STREAM: begin
                wait_cnt_d = '0;
                if (idx_q != IDX_LAST) idx_d = idx_q + AW'(1);
            end
            WAIT: begin
                if (bus.finish) begin
                    result_d  = bus.max;
                    timeout_d = 1'b0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    result_d  = '0;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            default: ;
        endcase

        busy_d    = (state_d != IDLE);
        eng_rst_d = (state_d == CLR);
        valid_d   = (state_d == STREAM);
        rvalid_d  = (state_d == HOLD);

        data_s_d = 2'b00;
        data_t_d = 2'b00;
        if (valid_d && ({1'b0, idx_d} < S_RLIM)) data_s_d = s_mem[idx_d];
        if (valid_d && ({1'b0, idx_d} < T_RLIM)) data_t_d = t_mem[idx_d];
    end

    assign bus.busy         = busy_q;
    assign bus.eng_rst      = eng_rst_q;
    assign bus.valid        = valid_q;
    assign bus.data_s       = data_s_q;
    assign bus.data_t       = data_t_q;
    assign bus.result_valid = rvalid_q;
    assign bus.result       = result_q;
    assign bus.timeout      = timeout_q;
endmodule

// File: tb/tb_sw_job_feeder.sv
// Directed bench for sw_job_feeder: a 64/64 instance and an 8/4 instance
// with a short timeout, sharing one host stimulus path selected by sel.
module tb_sw_job_feeder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        wr_en = 1'b0;
    logic        wr_sel = 1'b0;
    logic [6:0]  wr_addr = '0;
    logic [1:0]  wr_data = '0;
    logic        start = 1'b0;
    logic        finish = 1'b0;
    logic [11:0] max_v = '0;
    logic        result_ready = 1'b0;

    sw_job_feeder_if #(.ADDR_W(7)) ifa ();
    sw_job_feeder_if #(.ADDR_W(7)) ifb ();

    assign ifa.wr_en        = wr_en;
    assign ifa.wr_sel       = wr_sel;
    assign ifa.wr_addr      = wr_addr;
    assign ifa.wr_data      = wr_data;
    assign ifa.start        = start & ~sel;
    assign ifa.finish       = finish;
    assign ifa.max          = max_v;
    assign ifa.result_ready = result_ready;
    assign ifb.wr_en        = wr_en;
    assign ifb.wr_sel       = wr_sel;
    assign ifb.wr_addr      = wr_addr;
    assign ifb.wr_data      = wr_data;
    assign ifb.start        = start & sel;
    assign ifb.finish       = finish;
    assign ifb.max          = max_v;
    assign ifb.result_ready = result_ready;

    sw_job_feeder dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    sw_job_feeder #(
        .S_LEN   (8),
        .T_LEN   (4),
        .TIMEOUT (16)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    wire        o_busy    = sel ? ifb.busy : ifa.busy;
    wire        o_eng_rst = sel ? ifb.eng_rst : ifa.eng_rst;
    wire        o_valid   = sel ? ifb.valid : ifa.valid;
    wire [1:0]  o_data_s  = sel ? ifb.data_s : ifa.data_s;
    wire [1:0]  o_data_t  = sel ? ifb.data_t : ifa.data_t;
    wire        o_rv      = sel ? ifb.result_valid : ifa.result_valid;
    wire [11:0] o_result  = sel ? ifb.result : ifa.result;
    wire        o_timeout = sel ? ifb.timeout : ifa.timeout;
    wire [20:0] outs = {o_busy, o_eng_rst, o_valid, o_data_s, o_data_t,
                        o_rv, o_result, o_timeout};

    logic [1:0] ms [64];
    logic [1:0] mt [64];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic host_write(input logic s, input int a, input logic [1:0] d);
        wr_en   = 1'b1;
        wr_sel  = s;
        wr_addr = 7'(a);
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered at the first negedge after the start edge.
    task automatic run_stream(input int l, input int sl, input int tl,
                              input int stop_at, input int poke_at);
        for (int c = 0; c < 2; c++) begin
            if (c > 0) @(negedge clk);
            chk("clr_eng_rst", o_eng_rst, 1);
            chk("clr_valid", o_valid, 0);
        end
        for (int i = 0; i < l; i++) begin
            @(negedge clk);
            wr_en = 1'b0;
            start = 1'b0;
            chk("valid", o_valid, 1);
            chk("stream_eng_rst", o_eng_rst, 0);
            chk("data_s", o_data_s, (i < sl) ? 32'(ms[i]) : 32'd0);
            chk("data_t", o_data_t, (i < tl) ? 32'(mt[i]) : 32'd0);
            if (i == stop_at) return;
            if (i == poke_at) begin
                wr_en   = 1'b1;
                wr_sel  = 1'b0;
                wr_addr = 7'd2;
                wr_data = ~ms[2];
                start   = 1'b1;
            end
        end
        @(negedge clk);
        wr_en = 1'b0;
        start = 1'b0;
        chk("valid_end", o_valid, 0);
        chk("data_end", {o_data_s, o_data_t}, 0);
        chk("wait_busy", o_busy, 1);
    endtask

    task automatic finish_job(input logic [11:0] m);
        finish       = 1'b1;
        max_v        = m;
        result_ready = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        chk("fj_rv", o_rv, 1);
        chk("fj_result", o_result, 32'(m));
        chk("fj_timeout", o_timeout, 0);
        @(negedge clk);
        chk("fj_rv_drop", o_rv, 0);
        chk("fj_idle", o_busy, 0);
        result_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outs", outs, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_outs", outs, 0);

        for (int i = 0; i < 64; i++) begin
            ms[i] = 2'(i % 4);
            mt[i] = 2'(3 - (i % 4));
            host_write(1'b0, i, ms[i]);
            host_write(1'b1, i, mt[i]);
        end
        host_write(1'b0, 100, 2'd3);

        // Job 1: slow finish, host stalls the result for 5 cycles.
        pulse_start();
        run_stream(64, 64, 64, -1, -1);
        chk("wait_rv", o_rv, 0);
        repeat (19) @(negedge clk);
        chk("wait_busy_late", o_busy, 1);
        finish = 1'b1;
        max_v  = 12'd77;
        @(negedge clk);
        finish = 1'b0;
        chk("j1_rv", o_rv, 1);
        chk("j1_result", o_result, 77);
        chk("j1_timeout", o_timeout, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("j1_hold", {o_rv, o_result}, {1'b1, 12'd77});
        end
        result_ready = 1'b1;
        @(negedge clk);
        chk("j1_rv_drop", o_rv, 0);
        chk("j1_idle", o_busy, 0);
        result_ready = 1'b0;

        // Job 2: reset at stream index 10, then a clean full job.
        pulse_start();
        run_stream(64, 64, 64, 10, -1);
        reset = 1'b1;
        #1;
        chk("rst_mid_outs", outs, 0);
        @(negedge clk);
        chk("rst_hold_outs", outs, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_outs", outs, 0);
        pulse_start();
        run_stream(64, 64, 64, -1, -1);
        finish_job(12'habc);

        // Job 3: write + start on the same edge; write + start mid-stream.
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_addr = 7'd0;
        wr_data = 2'd3;
        ms[0]   = 2'd3;
        start   = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        start = 1'b0;
        run_stream(64, 64, 64, -1, 5);
        finish_job(12'h123);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("no_queued_job", o_busy, 0);
        end
        pulse_start();
        run_stream(64, 64, 64, -1, -1);
        finish_job(12'hfff);

        // Short instance: S_LEN=8, T_LEN=4, TIMEOUT=16.
        sel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ms[i] = 2'((i + 1) % 4);
            host_write(1'b0, i, ms[i]);
        end
        for (int i = 0; i < 4; i++) begin
            mt[i] = 2'((2 * i + 1) % 4);
            host_write(1'b1, i, mt[i]);
        end
        host_write(1'b1, 5, 2'd3);

        // finish on the same edge as the timeout: finish wins.
        pulse_start();
        run_stream(8, 8, 4, -1, -1);
        repeat (15) @(negedge clk);
        chk("b1_rv_early", o_rv, 0);
        finish = 1'b1;
        max_v  = 12'd5;
        @(negedge clk);
        finish = 1'b0;
        chk("b1_rv", o_rv, 1);
        chk("b1_result", o_result, 5);
        chk("b1_timeout", o_timeout, 0);
        result_ready = 1'b1;
        @(negedge clk);
        chk("b1_idle", {o_rv, o_busy}, 0);
        result_ready = 1'b0;

        // No finish at all: abort after 16 WAIT cycles.
        pulse_start();
        run_stream(8, 8, 4, -1, -1);
        repeat (15) @(negedge clk);
        chk("b2_rv_early", o_rv, 0);
        @(negedge clk);
        chk("b2_rv", o_rv, 1);
        chk("b2_result", o_result, 0);
        chk("b2_timeout", o_timeout, 1);
        chk("b2_busy", o_busy, 1);
        result_ready = 1'b1;
        @(negedge clk);
        chk("b2_idle", {o_rv, o_busy}, 0);
        result_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
